arp_rx: RTL
===========

Name: arp_rx

Overview:
- GMII receive-side ARP frame parser. It sits directly upstream of the ARP control block and feeds it arp_rx_done and arp_rx_type.
- It checks each incoming frame: preamble/SFD, destination MAC (board or broadcast), EtherType 0x0806 and target IP equal to board IP.
- On a matching frame it latches the sender MAC and IP and pulses done with the opcode type.
- No FCS check. Frames addressed elsewhere are silently dropped.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC; frames to this address or FF:FF:FF:FF:FF:FF are accepted.
- BOARD_IP, 32'hC0_A8_01_0A, local IP (192.168.1.10); ARP target IP must match.

Ports:
- clk  input  1  GMII receive clock, 125 MHz; all logic on rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- gmii_rx_dv  input  1  receive data valid.
- gmii_rxd  input  8  receive byte; sampled only when gmii_rx_dv=1.
- arp_rx_done  output  1  one-cycle pulse: valid ARP frame for this board parsed.
- arp_rx_type  output  1  0 = request (opcode 1), 1 = reply (opcode 2); valid from the done pulse until the next done.
- src_mac  output  48  sender hardware address of the last accepted frame.
- src_ip  output  32  sender protocol address of the last accepted frame.

Behaviour:
- Reset (async, sys_rst=1): state=IDLE, counters cleared, arp_rx_done=0, arp_rx_type=0, src_mac=48'd0, src_ip=32'd0.
- States: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END.
- IDLE:
  - dv=1 and rxd=8'h55 -> PREAMBLE with cnt=1.
  - dv=1 with any other byte -> RX_END.
- PREAMBLE:
  - Expects bytes 2..7 = 8'h55, then byte 8 = 8'hD5, then -> ETH_HEAD.
  - Any mismatch -> RX_END.
- ETH_HEAD, 14 bytes:
  - Bytes 0-5 form the destination MAC. Accept only if it equals BOARD_MAC or all-ones.
  - Bytes 6-11 (source MAC) are ignored.
  - Bytes 12-13 must equal 16'h0806.
  - Destination or type failure is decided at byte 13 -> RX_END; otherwise -> ARP_DATA.
- ARP_DATA, 28 bytes:
  - Bytes 0-5: htype/ptype/hlen/plen, ignored.
  - Bytes 6-7: opcode; only 16'h0001 and 16'h0002 are valid.
  - Bytes 8-13: sender MAC, shifted into a temp register MSB-first.
  - Bytes 14-17: sender IP, temp register.
  - Bytes 18-23: target MAC, ignored.
  - Bytes 24-27: target IP, temp register.
  - After byte 27: if target IP == BOARD_IP and opcode is valid, then on the next clk arp_rx_done=1 for exactly 1 cycle. In that same cycle src_mac, src_ip and arp_rx_type update.
  - Either way -> RX_END.
- RX_END: consume padding/FCS; stay until dv=0, then -> IDLE.
- dv falling in PREAMBLE/ETH_HEAD/ARP_DATA -> IDLE immediately; no done, outputs unchanged.
- dv=0 for a single cycle between bytes counts as an end of frame (no gap tolerance).
- Latency: done asserts 1 clk after the last target-IP byte is sampled.
- Outputs only change on done, so the ARP control block may sample them during or after the pulse.
- Counter: 6-bit byte counter, cleared on each state change. No wrap is possible because the maximum count is 27.
- Back-to-back frames: after dv low for ≥1 cycle, IDLE accepts the next preamble. A minimum 1-cycle gap is required.
- Reset asserted mid-frame: immediate return to reset values. After release, the remainder of the frame starts in IDLE, sees a non-0x55 byte or mid-stream data, and drains via RX_END.

Decomposition:
- Shared package eth_pkg:
  - ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_TYPE_ARP=16'h0806.
  - ARP_OP_REQ=16'h0001, ARP_OP_REPLY=16'h0002.
  - ETH_HEAD_LEN=14, ARP_DATA_LEN=28.
  - MAC_BCAST=48'hFFFF_FFFF_FFFF.
  - State encoding (one-hot, 5 bits).
- No sub-module. The single FSM plus byte counter is inline, about 200 lines.

Test Plan:
- Broadcast ARP request (dest FF..FF, op 1, sender 00:0A:35:01:02:03 / C0A80102, target C0A8010A) -> one-cycle done, type=0, src_mac=48'h000A35010203, src_ip=32'hC0A80102.
- Unicast reply to BOARD_MAC, op 2, same sender -> done pulse, type=1. Also send it with target IP C0A8010B -> no done, outputs unchanged.
- EtherType 0x0800 frame, and a dest MAC 00:11:22:33:44:66 frame -> no done; FSM in RX_END until dv=0, then IDLE.
- dv dropped after ARP byte 20 -> no done; a valid request 1 cycle later -> done asserted correctly.
- Bad preamble (6×55 then D5) and opcode 0x0003 -> no done in either case.
- sys_rst pulsed mid-ARP_DATA -> all outputs zero immediately; the next full request after reset produces a correct done.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and receive FSM state encoding.
// Used by the GMII-side ARP receive parser.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;

    localparam logic [15:0] ARP_OP_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY = 16'h0002;

    localparam int PREAMBLE_LEN = 8;
    localparam int ETH_HEAD_LEN = 14;
    localparam int ARP_DATA_LEN = 28;

    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_PREAMBLE = 5'b00010,
        S_ETH_HEAD = 5'b00100,
        S_ARP_DATA = 5'b01000,
        S_RX_END   = 5'b10000
    } rx_state_t;

    function automatic logic op_valid(input logic [15:0] op);
        return (op == ARP_OP_REQ) || (op == ARP_OP_REPLY);
    endfunction

endpackage

// File: rtl/arp_rx_if.sv
// GMII receive byte stream in, parsed ARP result out.
// slave = parser side, master = MAC/stimulus side.
interface arp_rx_if;

    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  arp_rx_done, arp_rx_type, src_mac, src_ip
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output arp_rx_done, arp_rx_type, src_mac, src_ip
    );

endinterface

// File: rtl/arp_rx.sv
// GMII ARP frame parser: preamble, dest MAC, EtherType, target IP.
// Latches sender MAC/IP and pulses done for frames meant for us.
import eth_pkg::*;

module arp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
    input  logic     clk,
    input  logic     sys_rst,
    arp_rx_if.slave  rx
);

    localparam logic [5:0] PRE_LAST  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HEAD_LAST = 6'(ETH_HEAD_LEN - 1);
    localparam logic [5:0] ARP_LAST  = 6'(ARP_DATA_LEN - 1);

    rx_state_t   state;
    logic [5:0]  cnt;
    logic [47:0] dst_mac;
    logic [7:0]  type_hi;
    logic [15:0] opcode;
    logic [47:0] tmp_mac;
    logic [31:0] tmp_ip;
    logic [23:0] tgt_ip;

    logic        done_q;
    logic        type_q;
    logic [47:0] mac_q;
    logic [31:0] ip_q;

    logic        dv;
    logic [7:0]  rxd;
    logic        dst_ok;
    logic        type_ok;
    logic        tip_ok;

    assign dv  = rx.gmii_rx_dv;
    assign rxd = rx.gmii_rxd;

    // Last header/ARP byte is compared straight off the wire.
    assign dst_ok  = (dst_mac == BOARD_MAC) || (dst_mac == MAC_BCAST);
    assign type_ok = ({type_hi, rxd} == ETH_TYPE_ARP);
    assign tip_ok  = ({tgt_ip, rxd} == BOARD_IP);

    assign rx.arp_rx_done = done_q;
    assign rx.arp_rx_type = type_q;
    assign rx.src_mac     = mac_q;
    assign rx.src_ip      = ip_q;

    // Frame parsing FSM with byte counter and registered results.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            dst_mac <= 48'd0;
            type_hi <= 8'd0;
            opcode  <= 16'd0;
            tmp_mac <= 48'd0;
            tmp_ip  <= 32'd0;
            tgt_ip  <= 24'd0;
            done_q  <= 1'b0;
            type_q  <= 1'b0;
            mac_q   <= 48'd0;
            ip_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (dv) begin
                        if (rxd == ETH_PREAMBLE) begin
                            state <= S_PREAMBLE;
                            cnt   <= 6'd1;
                        end else begin
                            state <= S_RX_END;
                            cnt   <= 6'd0;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!dv) begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                    end else if (cnt == PRE_LAST) begin
                        state <= (rxd == ETH_SFD) ? S_ETH_HEAD : S_RX_END;
                        cnt   <= 6'd0;
                    end else if (rxd == ETH_PREAMBLE) begin
                        cnt <= cnt + 6'd1;
                    end else begin
                        state <= S_RX_END;
                        cnt   <= 6'd0;
                    end
                end
                S_ETH_HEAD: begin
                    if (!dv) begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                    end else begin
                        if (cnt < 6'd6)
                            dst_mac <= {dst_mac[39:0], rxd};
                        if (cnt == 6'd12)
                            type_hi <= rxd;
                        if (cnt == HEAD_LAST) begin
                            state <= (dst_ok && type_ok) ? S_ARP_DATA
                                                         : S_RX_END;
                            cnt   <= 6'd0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_ARP_DATA: begin
                    if (!dv) begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                    end else begin
                        if (cnt == 6'd6 || cnt == 6'd7)
                            opcode <= {opcode[7:0], rxd};
                        if (cnt >= 6'd8 && cnt <= 6'd13)
                            tmp_mac <= {tmp_mac[39:0], rxd};
                        if (cnt >= 6'd14 && cnt <= 6'd17)
                            tmp_ip <= {tmp_ip[23:0], rxd};
                        if (cnt >= 6'd24 && cnt <= 6'd26)
                            tgt_ip <= {tgt_ip[15:0], rxd};
                        if (cnt == ARP_LAST) begin
                            if (tip_ok && op_valid(opcode)) begin
                                done_q <= 1'b1;
                                type_q <= (opcode == ARP_OP_REPLY);
                                mac_q  <= tmp_mac;
                                ip_q   <= tmp_ip;
                            end
                            state <= S_RX_END;
                            cnt   <= 6'd0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_RX_END: begin
                    if (!dv) begin
                        state <= S_IDLE;
                        cnt   <= 6'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

endmodule
